// File: rtl/ula_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Holds the FSM state encoding and the slice function codes the benches use.
package ula_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // OP_XOR and OP_PASS_A are logic-mode codes (m=1); OP_XOR shares its code with OP_SUB.
    localparam logic [3:0] OP_ADD    = 4'b1001;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_XOR    = 4'b0110;
    localparam logic [3:0] OP_PASS_A = 4'b1111;

endpackage

// File: rtl/ula_seq_if.sv
// Request, response and slice-side signals of the nibble sequencer, bundled
// with views for the sequencer, its requester/consumer and the ALU slice.
interface ula_seq_if
    import ula_seq_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int WIDTH = NIBBLE_W * NIBBLES;

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_s;
    logic             req_m;
    logic             req_cin;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_f;
    logic             resp_cout;
    logic             resp_eq;
    logic             resp_zero;

    logic [3:0]       slc_a;
    logic [3:0]       slc_b;
    logic [3:0]       slc_s;
    logic             slc_m;
    logic             slc_cin;
    logic [3:0]       slc_f;
    logic [3:0]       slc_cout;
    logic             slc_eq;

    modport slave (
        input  req_valid, req_a, req_b, req_s, req_m, req_cin,
        output req_ready,
        output resp_valid, resp_f, resp_cout, resp_eq, resp_zero,
        input  resp_ready,
        output slc_a, slc_b, slc_s, slc_m, slc_cin,
        input  slc_f, slc_cout, slc_eq
    );

    modport master (
        output req_valid, req_a, req_b, req_s, req_m, req_cin,
        input  req_ready,
        input  resp_valid, resp_f, resp_cout, resp_eq, resp_zero,
        output resp_ready
    );

    modport slice (
        input  slc_a, slc_b, slc_s, slc_m, slc_cin,
        output slc_f, slc_cout, slc_eq
    );

endinterface

// File: rtl/ula_seq_slice.sv
// Behavioural 4-bit 74181-style ALU slice with active-high carry.
// Subtract (s=0110, m=0) computes A-B-cin and reports the borrow on cout[0].
module ula_seq_slice
    import ula_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic [3:0] cout,
    output logic       eq
);

    logic [3:0] p;
    logic [3:0] q;
    logic [4:0] sum;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        p    = '0;
        q    = '0;
        sum  = '0;
        f    = '0;
        cout = '0;
        eq   = (a == b);
        if (m == MODE_LOGIC) begin
            case (s)
                4'b0000: f = ~a;
                4'b0001: f = ~(a | b);
                4'b0010: f = ~a & b;
                4'b0011: f = 4'h0;
                4'b0100: f = ~(a & b);
                4'b0101: f = ~b;
                4'b0110: f = a ^ b;
                4'b0111: f = a & ~b;
                4'b1000: f = ~a | b;
                4'b1001: f = ~(a ^ b);
                4'b1010: f = b;
                4'b1011: f = a & b;
                4'b1100: f = 4'hF;
                4'b1101: f = a | ~b;
                4'b1110: f = a | b;
                default: f = a;
            endcase
        end else if (s == OP_SUB) begin
            sum  = {1'b0, a} - {1'b0, b} - {4'b0, cin};
            f    = sum[3:0];
            cout = {3'b0, sum[4]};
        end else begin
            // Remaining arithmetic codes follow the 74181 form F = P plus Q plus carry.
            case (s)
                4'b0000: begin p = a;      q = 4'h0;   end
                4'b0001: begin p = a | b;  q = 4'h0;   end
                4'b0010: begin p = a | ~b; q = 4'h0;   end
                4'b0011: begin p = 4'h0;   q = 4'hF;   end
                4'b0100: begin p = a;      q = a & ~b; end
                4'b0101: begin p = a | b;  q = a & ~b; end
                4'b0111: begin p = a & ~b; q = 4'hF;   end
                4'b1000: begin p = a;      q = a & b;  end
                4'b1001: begin p = a;      q = b;      end
                4'b1010: begin p = a | ~b; q = a & b;  end
                4'b1011: begin p = a & b;  q = 4'hF;   end
                4'b1100: begin p = a;      q = a;      end
                4'b1101: begin p = a | b;  q = a;      end
                4'b1110: begin p = a | ~b; q = a;      end
                default: begin p = a;      q = 4'hF;   end
            endcase
            sum  = {1'b0, p} + {1'b0, q} + {4'b0, cin};
            f    = sum[3:0];
            cout = {3'b0, sum[4]};
        end
    end

endmodule

// File: rtl/ula_seq_top.sv
// Pairs the nibble sequencer with its 4-bit ALU slice behind plain
// request/response ports.
module ula_seq_top
    import ula_seq_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_b,
    input  logic [3:0]                   req_s,
    input  logic                         req_m,
    input  logic                         req_cin,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  resp_f,
    output logic                         resp_cout,
    output logic                         resp_eq,
    output logic                         resp_zero,
    output logic                         busy
);

    ula_seq_if #(.NIBBLES(NIBBLES)) bus ();

    assign bus.req_valid  = req_valid;
    assign bus.req_a      = req_a;
    assign bus.req_b      = req_b;
    assign bus.req_s      = req_s;
    assign bus.req_m      = req_m;
    assign bus.req_cin    = req_cin;
    assign bus.resp_ready = resp_ready;
    assign req_ready      = bus.req_ready;
    assign resp_valid     = bus.resp_valid;
    assign resp_f         = bus.resp_f;
    assign resp_cout      = bus.resp_cout;
    assign resp_eq        = bus.resp_eq;
    assign resp_zero      = bus.resp_zero;

    ula_nibble_sequencer #(.NIBBLES(NIBBLES)) u_seq (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    ula_seq_slice u_slice (
        .a    (bus.slc_a),
        .b    (bus.slc_b),
        .s    (bus.slc_s),
        .m    (bus.slc_m),
        .cin  (bus.slc_cin),
        .f    (bus.slc_f),
        .cout (bus.slc_cout),
        .eq   (bus.slc_eq)
    );

endmodule

// File: rtl/ula_nibble_sequencer.sv
// Runs a WIDTH-bit ALU operation through one external 4-bit slice, one nibble
// per cycle LSB first, chaining the slice carry between nibbles.
module ula_nibble_sequencer
    import ula_seq_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic     clk,
    input  logic     rst,
    ula_seq_if.slave bus,
    output logic     busy
);

    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             cry_q,   cry_d;
    logic             eq_q,    eq_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [3:0]       s_q,     s_d;
    logic             m_q,     m_d;
    logic [WIDTH-1:0] res_q,   res_d;

    logic [IDX_W+1:0] nib_lsb;
    logic             unused_cout_hi;

    assign nib_lsb        = {idx_q, 2'b00};
    assign unused_cout_hi = ^bus.slc_cout[3:1];

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cry_q   <= 1'b0;
            eq_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cry_q   <= cry_d;
            eq_q    <= eq_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cry_d   = cry_q;
        eq_d    = eq_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    s_d     = bus.req_s;
                    m_d     = bus.req_m;
                    cry_d   = bus.req_cin;
                    idx_d   = '0;
                    eq_d    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[nib_lsb +: NIBBLE_W] = bus.slc_f;
                cry_d = bus.slc_cout[0];
                eq_d  = eq_q & bus.slc_eq;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The slice only sees operands while a nibble is in flight.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == DONE);
        busy           = (state_q == RUN) || (state_q == DONE);
        bus.slc_a      = '0;
        bus.slc_b      = '0;
        bus.slc_s      = '0;
        bus.slc_m      = 1'b0;
        bus.slc_cin    = 1'b0;
        if (state_q == RUN) begin
            bus.slc_a   = a_q[nib_lsb +: NIBBLE_W];
            bus.slc_b   = b_q[nib_lsb +: NIBBLE_W];
            bus.slc_s   = s_q;
            bus.slc_m   = m_q;
            bus.slc_cin = cry_q;
        end
    end

    assign bus.resp_f    = res_q;
    assign bus.resp_cout = cry_q;
    assign bus.resp_eq   = eq_q;
    assign bus.resp_zero = (res_q == '0);

endmodule

// File: tb/tb_ula_nibble_sequencer.sv
// Bench for ula_nibble_sequencer: directed cases plus random add/sub/xor/pass
// requests checked against whole-word arithmetic.
module tb_ula_nibble_sequencer;
    import ula_seq_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_bad    = 0;

    ula_seq_if #(.NIBBLES(N)) bus ();

    ula_nibble_sequencer #(.NIBBLES(N)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    ula_seq_slice u_slice (
        .a    (bus.slc_a),
        .b    (bus.slc_b),
        .s    (bus.slc_s),
        .m    (bus.slc_m),
        .cin  (bus.slc_cin),
        .f    (bus.slc_f),
        .cout (bus.slc_cout),
        .eq   (bus.slc_eq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Whole-word reference: returns {eq, cout, f}.
    function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] s, input logic m, input logic cin);
        logic [W:0] r;
        if (!m && s == OP_ADD)      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        else if (!m && s == OP_SUB) r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        else if (m && s == OP_XOR)  r = {1'b0, a ^ b};
        else                        r = {1'b0, a};
        return {a == b, r};
    endfunction

    // Carry (or borrow) entering nibble k, from arithmetic on the low 4k bits.
    function automatic logic exp_carry_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] s, input logic m, input logic cin, input int k);
        logic [W:0] mask;
        logic [W:0] lo;
        if (k == 0) return cin;
        if (m) return 1'b0;
        mask = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
        if (s == OP_SUB) begin
            lo = ({1'b0, a} & mask) - ({1'b0, b} & mask) - {{W{1'b0}}, cin};
            return lo[W];
        end
        lo = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, cin};
        return lo[4 * k];
    endfunction

    task automatic scramble_req();
        bus.req_a   = W'($urandom);
        bus.req_b   = W'($urandom);
        bus.req_s   = 4'($urandom);
        bus.req_m   = 1'($urandom);
        bus.req_cin = 1'($urandom);
    endtask

    task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] s, input logic m, input logic cin, input int hold,
                           output logic [W-1:0] got_f, output logic got_cout, output logic got_eq,
                           output logic got_zero, output logic [15:0] cin_seq);
        logic [W+1:0] exp;
        int lat;
        exp     = model_op(a, b, s, m, cin);
        cin_seq = '0;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_s     = s;
        bus.req_m     = m;
        bus.req_cin   = cin;
        bus.req_valid = 1'b1;
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble_req();
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            if (lat < N) begin
                cin_seq[lat] = bus.slc_cin;
                check({tag, "_slc_cin"}, 64'(bus.slc_cin), 64'(exp_carry_in(a, b, s, m, cin, lat)));
                check({tag, "_slc_a"}, 64'(bus.slc_a), 64'(a[4*lat +: 4]));
                check({tag, "_slc_b"}, 64'(bus.slc_b), 64'(b[4*lat +: 4]));
                check({tag, "_slc_sm"}, 64'({bus.slc_s, bus.slc_m}), 64'({s, m}));
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(N));
        got_f    = bus.resp_f;
        got_cout = bus.resp_cout;
        got_eq   = bus.resp_eq;
        got_zero = bus.resp_zero;
        check({tag, "_f"}, 64'(got_f), 64'(exp[W-1:0]));
        check({tag, "_cout"}, 64'(got_cout), 64'(exp[W]));
        check({tag, "_eq"}, 64'(got_eq), 64'(exp[W+1]));
        check({tag, "_zero"}, 64'(got_zero), 64'(exp[W-1:0] == '0));
        check({tag, "_done_busy"}, 64'({busy, bus.req_ready}), 64'(2'b10));
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            scramble_req();
            @(posedge clk); #1;
            check({tag, "_hold_f"}, 64'(bus.resp_f), 64'(exp[W-1:0]));
            check({tag, "_hold_vr"}, 64'({bus.resp_valid, bus.req_ready}), 64'(2'b10));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        check({tag, "_after_hs"}, 64'({bus.resp_valid, bus.req_ready, busy}), 64'(3'b010));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] f;
        logic         co, eq, z, seen;
        logic [15:0]  cs;
        logic [3:0]   s;
        logic         m, cin;
        logic [W-1:0] a, b;

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_s      = '0;
        bus.req_m      = 1'b0;
        bus.req_cin    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready_valid_busy", 64'({bus.req_ready, bus.resp_valid, busy}), 64'(3'b100));
        check("rst_slc", 64'({bus.slc_a, bus.slc_b, bus.slc_s, bus.slc_m, bus.slc_cin}), 64'(0));

        run_txn("add_carry8", 16'h00FF, 16'h0001, OP_ADD, MODE_ARITH, 1'b0, 0, f, co, eq, z, cs);
        check("add_carry8_lit", 64'({f, co}), 64'({16'h0100, 1'b0}));

        run_txn("add_wrap", 16'hFFFF, 16'h0001, OP_ADD, MODE_ARITH, 1'b0, 1, f, co, eq, z, cs);
        check("add_wrap_lit", 64'({f, co, z}), 64'({16'h0000, 1'b1, 1'b1}));

        run_txn("add_cin", 16'h1234, 16'h1111, OP_ADD, MODE_ARITH, 1'b1, 0, f, co, eq, z, cs);
        check("add_cin_lit", 64'(f), 64'(16'h2346));

        run_txn("sub", 16'h0100, 16'h0001, OP_SUB, MODE_ARITH, 1'b0, 0, f, co, eq, z, cs);
        check("sub_lit", 64'(f), 64'(16'h00FF));
        check("sub_cin_seq", 64'(cs[3:0]), 64'(4'b0110));

        run_txn("xor", 16'hA5A5, 16'h0FF0, OP_XOR, MODE_LOGIC, 1'b0, 0, f, co, eq, z, cs);
        check("xor_lit", 64'({f, co, eq}), 64'({16'hAA55, 1'b0, 1'b0}));

        run_txn("xor_eq", 16'h1234, 16'h1234, OP_XOR, MODE_LOGIC, 1'b0, 0, f, co, eq, z, cs);
        check("xor_eq_lit", 64'({eq, z}), 64'(2'b11));

        run_txn("backpressure", 16'h7777, 16'h1111, OP_ADD, MODE_ARITH, 1'b0, 5, f, co, eq, z, cs);
        check("backpressure_lit", 64'(f), 64'(16'h8888));

        // Reset in the middle of RUN, while nibble 2 is on the slice.
        bus.req_a     = 16'h0F0F;
        bus.req_b     = 16'h0101;
        bus.req_s     = OP_ADD;
        bus.req_m     = MODE_ARITH;
        bus.req_cin   = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("midrst_idx2_slc_a", 64'({busy, bus.slc_a}), 64'({1'b1, 4'hF}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_state", 64'({bus.req_ready, bus.resp_valid, busy}), 64'(3'b100));
        check("midrst_slc", 64'({bus.slc_a, bus.slc_b, bus.slc_s, bus.slc_m, bus.slc_cin}), 64'(0));
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen = 1'b1;
        end
        check("midrst_no_resp", 64'(seen), 64'(0));
        run_txn("post_rst_add", 16'h0F0F, 16'h0101, OP_ADD, MODE_ARITH, 1'b0, 0, f, co, eq, z, cs);
        check("post_rst_add_lit", 64'(f), 64'(16'h1010));

        for (int t = 0; t < 30; t++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 3))
                0:       begin s = OP_ADD;    m = MODE_ARITH; end
                1:       begin s = OP_SUB;    m = MODE_ARITH; end
                2:       begin s = OP_XOR;    m = MODE_LOGIC; end
                default: begin s = OP_PASS_A; m = MODE_LOGIC; end
            endcase
            cin = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       b = a;
                1:       b = W'(0) - a;
                default: ;
            endcase
            run_txn("rand", a, b, s, m, cin, $urandom_range(0, 3), f, co, eq, z, cs);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/ula_nibble_sequencer.md
Name: ula_nibble_sequencer

Overview:
Controller that performs WIDTH-bit arithmetic/logic operations by time-multiplexing one external 4-bit 74181-style ALU slice over successive nibbles, LSB first. The carry/borrow from each nibble feeds the next. It sits between a requester (valid/ready request channel) and a consumer (valid/ready response channel), and owns the slice's operand, function and carry inputs.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; WIDTH = 4*NIBBLES; legal range 2..16.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept (high only in IDLE)
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
req_s  input  4  function select, passed unchanged to the slice
req_m  input  1  mode: 0 arithmetic, 1 logic
req_cin  input  1  carry into nibble 0
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_f  output  WIDTH  assembled result
resp_cout  output  1  slc_cout[0] from the last nibble
resp_eq  output  1  AND of slc_eq over all nibbles (A == B)
resp_zero  output  1  resp_f == 0
busy  output  1  high in RUN or DONE
slc_a, slc_b  output  4  current nibble of latched A/B
slc_s  output  4  latched s
slc_m  output  1  latched m
slc_cin  output  1  carry into current nibble
slc_f  input  4  slice result
slc_cout  input  4  slice carry; only bit 0 is used
slc_eq  input  1  slice nibble equality

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- FSM states: IDLE, RUN, DONE. Nibble index idx is ceil(log2 NIBBLES) bits wide. Carry register is cry.
- Reset: state=IDLE, idx=0, cry=0. All result registers are 0; resp_valid=0, busy=0, req_ready=1. All slc_* outputs are 0.
- IDLE: req_ready=1. On req_valid&&req_ready, latch a, b, s, m, cin. Then set idx=0, cry=cin, eq_acc=1, go to RUN.
- RUN (one nibble per cycle): slc_a=A[4*idx+:4], slc_b=B[4*idx+:4], slc_s/slc_m=latched values, slc_cin=cry. At each clock edge:
  - result[4*idx+:4] <= slc_f
  - cry <= slc_cout[0]
  - eq_acc <= eq_acc & slc_eq
  - idx <= idx+1
  - When idx==NIBBLES-1, go to DONE instead of incrementing.
- Latency: acceptance on edge T; RUN during cycles T+1..T+NIBBLES; resp_valid rises after edge T+NIBBLES.
- DONE: resp_valid=1. resp_f, resp_cout(=cry), resp_eq and resp_zero stay stable until handshake. On resp_ready, go to IDLE; req_ready is 1 in the next cycle. No new request is accepted in the same cycle as the response handshake.
- Logic mode (m=1): identical sequencing, and the carry is still chained. The slice returns 0 carry, so resp_cout=0.
- Subtract (s=0110, m=0): slc_cout[0] is the borrow and propagates as slc_cin. With req_cin=0 the result is a plain A-B mod 2^WIDTH.
- Outside RUN, slc_* outputs are driven to 0.
- Inputs req_* are ignored while req_ready=0. Changes to them during RUN have no effect.
- Reset asserted in RUN or DONE: the transaction is discarded. Next cycle state=IDLE, resp_valid=0, and no response is produced.
- resp_ready while resp_valid=0 is ignored.

Decomposition:
- Package ula_seq_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - NIBBLE_W=4
  - localparams for the function codes used by benches: OP_ADD=4'b1001, OP_SUB=4'b0110, OP_XOR=4'b0110 with m=1, OP_PASS_A=4'b1111 with m=1
- No sub-module inside the sequencer. The ALU slice is instantiated beside it in a wrapper, ula_seq_top, which ties the slc_* ports to the slice.

Test Plan:
- NIBBLES=4, add m=0 s=1001, a=0x00FF b=0x0001 cin=0 -> resp_f=0x0100, resp_cout=0, resp_valid rises exactly 4 cycles after acceptance.
- Add a=0xFFFF b=0x0001 cin=0 -> resp_f=0x0000, resp_cout=1, resp_zero=1. Also a=0x1234 b=0x1111 cin=1 -> resp_f=0x2346.
- Subtract m=0 s=0110, a=0x0100 b=0x0001 cin=0 -> resp_f=0x00FF. slc_cin sequence per nibble is 0,1,1,0.
- Logic XOR m=1 s=0110, a=0xA5A5 b=0x0FF0 -> resp_f=0xAA55, resp_cout=0, resp_eq=0. A second request with a=b=0x1234 -> resp_eq=1.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_f stable, req_ready=0, a pending req_valid is not accepted. Release -> one handshake, then IDLE.
- Assert rst during RUN at idx=2 -> next cycle IDLE, busy=0, slc_* = 0, no resp_valid ever for that request. A following add completes normally.
